// File: rtl/mmio_peripheral_responder_if.sv
// CPU IO-bus signals between the core's memory/IO steering logic and the IO responder.
// The read data path is combinational and comes back from the slave.
interface mmio_peripheral_responder_if;
    logic        r_io_en;
    logic        w_io_en;
    logic [31:0] adr_in;
    logic [31:0] w_io_dat;
    logic [31:0] r_io_dat;

    modport master (
        output r_io_en,
        output w_io_en,
        output adr_in,
        output w_io_dat,
        input  r_io_dat
    );

    modport slave (
        input  r_io_en,
        input  w_io_en,
        input  adr_in,
        input  w_io_dat,
        output r_io_dat
    );
endinterface

// File: rtl/mmio_peripheral_responder.sv
// IO responder: LED register, debounced switches/buttons with sticky press bits, and a
// free-running cycle counter. Reads are combinational; all state changes on the rising edge.
module mmio_peripheral_responder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [31:0] BASE_ADR        = 32'hFFFF_FC00
) (
    input  logic                         clk,
    input  logic                         rst,
    mmio_peripheral_responder_if.slave   bus,
    input  logic [15:0]                  sw_in,
    input  logic [4:0]                   btn_in,
    output logic [15:0]                  led_out,
    output logic                         io_err
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    localparam logic [31:0] AdrLed = BASE_ADR + 32'h60;
    localparam logic [31:0] AdrSw  = BASE_ADR + 32'h70;
    localparam logic [31:0] AdrBtn = BASE_ADR + 32'h74;
    localparam logic [31:0] AdrLvl = BASE_ADR + 32'h78;
    localparam logic [31:0] AdrCyc = BASE_ADR + 32'h7C;

    logic [15:0]     led_q, led_d;
    logic            io_err_q;
    logic [15:0]     sw_sync1_q, sw_sync2_q;
    logic [4:0]      btn_sync1_q, btn_sync2_q;
    logic [15:0]     sw_stable_q, sw_stable_d;
    logic [4:0]      btn_stable_q, btn_stable_d;
    logic [4:0]      btn_sticky_q, btn_sticky_d;
    logic [CntW-1:0] sw_cnt_q, sw_cnt_d;
    logic [CntW-1:0] btn_cnt_q [5];
    logic [CntW-1:0] btn_cnt_d [5];
    logic [31:0]     cyc_q, cyc_d;

    logic hit_led, hit_sw, hit_btn, hit_lvl, hit_cyc;
    logic mapped, any_access, illegal, wr_ok;

    // Full 32-bit compare, so any misaligned address is simply unmapped.
    assign hit_led = (bus.adr_in == AdrLed);
    assign hit_sw  = (bus.adr_in == AdrSw);
    assign hit_btn = (bus.adr_in == AdrBtn);
    assign hit_lvl = (bus.adr_in == AdrLvl);
    assign hit_cyc = (bus.adr_in == AdrCyc);
    assign mapped  = hit_led | hit_sw | hit_btn | hit_lvl | hit_cyc;

    assign any_access = bus.r_io_en | bus.w_io_en;
    assign illegal    = (bus.r_io_en & bus.w_io_en) | (any_access & ~mapped) |
                        (bus.w_io_en & (hit_sw | hit_lvl));
    assign wr_ok      = bus.w_io_en & ~illegal;

    always_comb begin
        bus.r_io_dat = 32'h0;
        if (!rst && bus.r_io_en) begin
            unique case (1'b1)
                hit_led: bus.r_io_dat = {16'h0, led_q};
                hit_sw:  bus.r_io_dat = {16'h0, sw_stable_q};
                hit_btn: bus.r_io_dat = {27'h0, btn_sticky_q};
                hit_lvl: bus.r_io_dat = {27'h0, btn_stable_q};
                hit_cyc: bus.r_io_dat = cyc_q;
                default: bus.r_io_dat = 32'h0;
            endcase
        end
    end

    always_comb begin
        sw_stable_d = sw_stable_q;
        sw_cnt_d    = '0;
        if (sw_sync2_q != sw_stable_q) begin
            if (sw_cnt_q == CntMax) begin
                sw_stable_d = sw_sync2_q;
            end else begin
                sw_cnt_d = sw_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        btn_stable_d = btn_stable_q;
        for (int i = 0; i < 5; i++) begin
            btn_cnt_d[i] = '0;
            if (btn_sync2_q[i] != btn_stable_q[i]) begin
                if (btn_cnt_q[i] == CntMax) begin
                    btn_stable_d[i] = btn_sync2_q[i];
                end else begin
                    btn_cnt_d[i] = btn_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // A new press is OR-ed in after the clear so that it survives a same-cycle W1C.
    always_comb begin
        btn_sticky_d = btn_sticky_q;
        if (wr_ok && hit_btn) begin
            btn_sticky_d = btn_sticky_d & ~bus.w_io_dat[4:0];
        end
        btn_sticky_d = btn_sticky_d | (btn_stable_d & ~btn_stable_q);
    end

    always_comb begin
        led_d = led_q;
        if (wr_ok && hit_led) begin
            led_d = bus.w_io_dat[15:0];
        end
        cyc_d = (wr_ok && hit_cyc) ? 32'h0 : cyc_q + 32'h1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q        <= '0;
            io_err_q     <= 1'b0;
            sw_sync1_q   <= '0;
            sw_sync2_q   <= '0;
            btn_sync1_q  <= '0;
            btn_sync2_q  <= '0;
            sw_stable_q  <= '0;
            btn_stable_q <= '0;
            btn_sticky_q <= '0;
            sw_cnt_q     <= '0;
            btn_cnt_q    <= '{default: '0};
            cyc_q        <= '0;
        end else begin
            led_q        <= led_d;
            io_err_q     <= illegal;
            sw_sync1_q   <= sw_in;
            sw_sync2_q   <= sw_sync1_q;
            btn_sync1_q  <= btn_in;
            btn_sync2_q  <= btn_sync1_q;
            sw_stable_q  <= sw_stable_d;
            btn_stable_q <= btn_stable_d;
            btn_sticky_q <= btn_sticky_d;
            sw_cnt_q     <= sw_cnt_d;
            btn_cnt_q    <= btn_cnt_d;
            cyc_q        <= cyc_d;
        end
    end

    assign led_out = led_q;
    assign io_err  = io_err_q;

endmodule
